uart_cmd_rx: RTL and testbench

//  8N1 UART receiver: the far end of the BLE/host command link. It deserialises the serial RX line
//  (driven by the command UART transmitter) into bytes for the Segway command/auth logic.

---
 rtl/uart_cmd_rx.sv | 157 +++++++++++++++
 tb/tb_uart_cmd_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver for the host/BLE command link.
// Two-flop synchroniser on RX, mid-bit sampling from a down-counting baud timer,
// false-start rejection, framing/overrun flags, and byte hold until clr_rdy.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line idle; waits for a falling edge (or for RX high after a break)
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sample 8 data bits LSB first at bit centres
// STOP  | sample the stop bit, publish the byte or flag a framing error
module uart_cmd_rx #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam logic [15:0] FULL_CNT = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_CNT = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rdy_q, rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        ovr_err_q, ovr_err_d;
    logic        armed_q, armed_d;
    logic        tick;

    // Next-state logic: synchroniser, baud timer, frame FSM and output flags.
    always_comb begin
        state_d    = state_q;
        rx_meta_d  = RX;
        rx_s_d     = rx_meta_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rdy_d      = rdy_q;
        frm_err_d  = frm_err_q;
        ovr_err_d  = ovr_err_q;
        armed_d    = armed_q;
        tick       = (baud_cnt_q == 16'd0);

        if (state_q != IDLE && !tick) begin
            baud_cnt_d = baud_cnt_q - 16'd1;
        end

        if (clr_rdy) begin
            rdy_d     = 1'b0;
            ovr_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!armed_q) begin
                    // After a break, wait for the line to return high first.
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end
                end else if (!rx_s_q) begin
                    state_d    = START;
                    baud_cnt_d = HALF_CNT;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DATA;
                        baud_cnt_d = FULL_CNT;
                        bit_cnt_d  = 4'd0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d    = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    baud_cnt_d = FULL_CNT;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets a back-to-back start edge be caught.
                if (tick) begin
                    state_d = IDLE;
                    if (rx_s_q) begin
                        rx_data_d = shift_q;
                        rdy_d     = 1'b1;
                        frm_err_d = 1'b0;
                        ovr_err_d = rdy_q && !clr_rdy;
                    end else begin
                        frm_err_d = 1'b1;
                        armed_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rdy_q      <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            frm_err_q  <= frm_err_d;
            ovr_err_q  <= ovr_err_d;
            armed_q    <= armed_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: a directed vector table, hand-written corner sequences
// (false start, reset mid-frame, break) and random frames against a frame-level model.
module tb_uart_cmd_rx;

    localparam int BD = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr_err;

    int total = 0;
    int bad = 0;

    // frame-level reference model state
    logic [7:0] m_data;
    logic       m_rdy, m_frm, m_ovr;

    typedef struct {
        logic [7:0] d;
        logic       stop_ok;
        logic       clr;
        int         gap;
        logic [7:0] e_data;
        logic       e_rdy;
        logic       e_frm;
        logic       e_ovr;
    } vec_t;

    vec_t vecs[6];

    uart_cmd_rx #(.BAUD_DIV(BD)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] d, input logic r,
                           input logic f, input logic o);
        chk({nm, ".rx_data"}, int'(rx_data), int'(d));
        chk({nm, ".rdy"}, int'(rdy), int'(r));
        chk({nm, ".frm_err"}, int'(frm_err), int'(f));
        chk({nm, ".ovr_err"}, int'(ovr_err), int'(o));
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        @(negedge clk);
        RX = 1'b0;
        wait_clks(BD);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            wait_clks(BD);
        end
        RX = stop_ok;
        wait_clks(BD);
        RX = 1'b1;
    endtask

    // model: apply consumer ack, then the outcome of one frame
    task automatic model_clr();
        m_rdy = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop_ok);
        if (stop_ok) begin
            m_ovr  = m_rdy;
            m_rdy  = 1'b1;
            m_data = d;
            m_frm  = 1'b0;
        end else begin
            m_frm = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic       rs, rc, prev_bad;
        int         rg;

        vecs[0] = '{8'h47, 1'b1, 1'b0, 2, 8'h47, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h53, 1'b1, 1'b1, 2, 8'h53, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hA5, 1'b0, 1'b1, 2, 8'h53, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, 2, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h11, 1'b1, 1'b1, 2, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h22, 1'b1, 1'b0, 0, 8'h22, 1'b1, 1'b0, 1'b1};

        wait_clks(4);
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        wait_clks(2 * BD);
        chk_all("idle_after_reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // directed table: good frames, framing error, recovery, overrun
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].clr) pulse_clr();
            wait_clks(vecs[i].gap * BD);
            send_frame(vecs[i].d, vecs[i].stop_ok);
            chk_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_rdy,
                    vecs[i].e_frm, vecs[i].e_ovr);
        end

        pulse_clr();
        wait_clks(1);
        chk_all("clr_after_ovr", 8'h22, 1'b0, 1'b0, 1'b0);

        // false start shorter than half a bit
        wait_clks(BD);
        RX = 1'b0;
        wait_clks(10);
        RX = 1'b1;
        wait_clks(3 * BD);
        chk_all("glitch", 8'h22, 1'b0, 1'b0, 1'b0);
        send_frame(8'h96, 1'b1);
        chk_all("after_glitch", 8'h96, 1'b1, 1'b0, 1'b0);

        // reset in the middle of the 4th data bit of 8'hFF
        wait_clks(BD);
        RX = 1'b0;
        wait_clks(BD);
        RX = 1'b1;
        wait_clks(3 * BD + BD / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all("rst_midframe", 8'h00, 1'b0, 1'b0, 1'b0);
        wait_clks(6 * BD);
        chk_all("rst_no_ghost", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1);
        chk_all("after_rst", 8'h5A, 1'b1, 1'b0, 1'b0);

        // break: line low for 20 bit times
        pulse_clr();
        wait_clks(BD);
        RX = 1'b0;
        wait_clks(20 * BD);
        chk_all("break_low", 8'h5A, 1'b0, 1'b1, 1'b0);
        RX = 1'b1;
        wait_clks(2 * BD);
        chk_all("break_release", 8'h5A, 1'b0, 1'b1, 1'b0);
        send_frame(8'h47, 1'b1);
        chk_all("after_break", 8'h47, 1'b1, 1'b0, 1'b0);

        // randomized frames against the model
        m_data   = 8'h47;
        m_rdy    = 1'b1;
        m_frm    = 1'b0;
        m_ovr    = 1'b0;
        prev_bad = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 4) != 0);
            rc = 1'($urandom_range(0, 1));
            rg = prev_bad ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            if (rc) begin
                pulse_clr();
                model_clr();
            end
            wait_clks(rg * BD);
            send_frame(rd, rs);
            model_frame(rd, rs);
            chk_all($sformatf("rand%0d", i), m_data, m_rdy, m_frm, m_ovr);
            prev_bad = !rs;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
